// File: rtl/uart_ctrl_pkg.sv
// Register map, STATUS/CTRL bit positions and the flag returned by a read of an empty RX FIFO.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_e;

    // Byte offsets as seen on the bus
    localparam logic [3:0] OFS_DATA   = 4'h0;
    localparam logic [3:0] OFS_STATUS = 4'h4;
    localparam logic [3:0] OFS_CTRL   = 4'h8;
    localparam logic [3:0] OFS_RSVD   = 4'hC;

    // STATUS layout
    localparam int ST_RX_CNT_LSB = 0;
    localparam int ST_TX_CNT_LSB = 8;
    localparam int ST_RX_EMPTY   = 16;
    localparam int ST_TX_FULL    = 17;
    localparam int ST_TX_OVF     = 18;
    localparam int ST_RX_FULL    = 19;

    // CTRL layout
    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;

    localparam logic [31:0] RD_EMPTY_FLAG = 32'h8000_0000;

endpackage

// File: rtl/uart_ctrl_if.sv
// Single-cycle request peripheral bus: one req strobe, ack exactly one cycle later.
interface uart_ctrl_if;
    logic        req;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/uart_ctrl_sync_fifo.sv
// Synchronous show-ahead FIFO; full/empty/count come from registered state only,
// so a push into a full FIFO is refused even when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    // Head forced to 0 when empty so the output is defined straight out of reset
    assign dout_o  = empty_o ? '0 : mem_q[rptr_q];

    // Occupancy: simultaneous push and pop leaves it unchanged
    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage; contents are meaningless after reset since pointers restart
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_ctrl.sv
// Bus-side UART controller: TX/RX FIFOs behind DATA/STATUS/CTRL registers.
// Optional interrupt output and CTRL register: define UART_CTRL_IRQ_EN.
module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_ctrl_if.slave           bus,
    output logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    input  logic [DATA_BITS-1:0] rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready
`ifdef UART_CTRL_IRQ_EN
   ,output logic                 irq
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    reg_sel_e             sel;
    logic                 rd, wr;
    logic                 tx_push, tx_full, tx_empty;
    logic                 rx_pop, rx_full, rx_empty;
    logic [CW-1:0]        tx_count, rx_count;
    logic [7:0]           tx_cnt8, rx_cnt8;
    logic [DATA_BITS-1:0] rx_head;

    logic        ack_q, ack_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ovf_q, ovf_d;
    logic [31:0] ctrl_rd;

    logic unused_bus_bits;
    assign unused_bus_bits = ^{bus.addr[1:0], bus.wdata};

    assign sel = reg_sel_e'(bus.addr[3:2]);
    assign rd  = bus.req && !bus.we;
    assign wr  = bus.req && bus.we;

    assign tx_push  = wr && (sel == REG_DATA);
    assign rx_pop   = rd && (sel == REG_DATA);
    assign tx_valid = !tx_empty;
    assign rx_ready = !rx_full;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (tx_push),
        .din_i   (bus.wdata[DATA_BITS-1:0]),
        .pop_i   (tx_ready),
        .dout_o  (tx_data),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (rx_valid),
        .din_i   (rx_data),
        .pop_i   (rx_pop),
        .dout_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    // Zero-extend the FIFO occupancies into the 8-bit STATUS fields
    always_comb begin
        tx_cnt8 = '0;
        rx_cnt8 = '0;
        tx_cnt8[CW-1:0] = tx_count;
        rx_cnt8[CW-1:0] = rx_count;
    end

`ifdef UART_CTRL_IRQ_EN
    logic [1:0] ctrl_q, ctrl_d;
    logic       irq_q, irq_d;

    // CTRL holds the two interrupt enables
    always_comb begin
        ctrl_d = ctrl_q;
        if (wr && (sel == REG_CTRL))
            ctrl_d = {bus.wdata[CTRL_TX_IRQ_EN], bus.wdata[CTRL_RX_IRQ_EN]};
        irq_d = (ctrl_q[CTRL_RX_IRQ_EN] && !rx_empty) ||
                (ctrl_q[CTRL_TX_IRQ_EN] && tx_empty);
        ctrl_rd = '0;
        ctrl_rd[CTRL_RX_IRQ_EN] = ctrl_q[CTRL_RX_IRQ_EN];
        ctrl_rd[CTRL_TX_IRQ_EN] = ctrl_q[CTRL_TX_IRQ_EN];
    end

    // Interrupt enables and registered interrupt line
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign ctrl_rd = '0;
`endif

    // Sticky overflow: set on a refused DATA write, cleared by writing 1 to its STATUS bit
    always_comb begin
        ovf_d = ovf_q;
        if (tx_push && tx_full) ovf_d = 1'b1;
        else if (wr && (sel == REG_STATUS) && bus.wdata[ST_TX_OVF]) ovf_d = 1'b0;
    end

    // Read data mux; only reads return data, writes and idle cycles give 0
    always_comb begin
        rdata_d = '0;
        ack_d   = bus.req;
        if (rd) begin
            case (sel)
                REG_DATA: begin
                    if (rx_empty) rdata_d = RD_EMPTY_FLAG;
                    else          rdata_d[DATA_BITS-1:0] = rx_head;
                end
                REG_STATUS: begin
                    rdata_d[ST_RX_CNT_LSB +: 8] = rx_cnt8;
                    rdata_d[ST_TX_CNT_LSB +: 8] = tx_cnt8;
                    rdata_d[ST_RX_EMPTY]        = rx_empty;
                    rdata_d[ST_TX_FULL]         = tx_full;
                    rdata_d[ST_TX_OVF]          = ovf_q;
                    rdata_d[ST_RX_FULL]         = rx_full;
                end
                REG_CTRL: rdata_d = ctrl_rd;
                default:  rdata_d = '0;
            endcase
        end
    end

    // Bus response and overflow flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed bench for uart_ctrl; also exercises the interrupt when UART_CTRL_IRQ_EN is defined.
module tb_uart_ctrl;
    import uart_ctrl_pkg::*;

    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DB-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [DB-1:0] rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
`ifdef UART_CTRL_IRQ_EN
    logic          irq;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] rd;

    uart_ctrl_if bus ();

    uart_ctrl #(.DATA_BITS(DB), .FIFO_DEPTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready)
`ifdef UART_CTRL_IRQ_EN
       ,.irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Callers are positioned 1ns after a rising edge; req is sampled at the next edge
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
        @(posedge clk); #1;
        bus.req = 1'b0; bus.we = 1'b0;
        chk("wr_ack", {31'd0, bus.ack}, 32'd1);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = a; bus.wdata = '0;
        @(posedge clk); #1;
        bus.req = 1'b0;
        d = bus.rdata;
        chk("rd_ack", {31'd0, bus.ack}, 32'd1);
    endtask

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;

        // Reset state
        #23;
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data",  {24'd0, tx_data},  32'd0);
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
        chk("rst_ack",      {31'd0, bus.ack},  32'd0);
        chk("rst_rdata",    bus.rdata,         32'd0);
        @(negedge clk); rst = 1'b1;
        cycle();

        bus_read(OFS_STATUS, rd); chk("status_reset", rd, 32'h0001_0000);
        bus_read(OFS_DATA, rd);   chk("data_empty",   rd, 32'h8000_0000);
        bus_read(OFS_RSVD, rd);   chk("rsvd_read",    rd, 32'h0);
        cycle();
        chk("ack_idle", {31'd0, bus.ack}, 32'd0);

        // Two TX writes held by tx_ready=0
        bus_write(OFS_DATA, 32'h0000_0041);
        chk("tx_valid_after_wr", {31'd0, tx_valid}, 32'd1);
        bus_write(OFS_DATA, 32'h0000_0042);
        cycle(); cycle();
        chk("tx_head_held", {24'd0, tx_data}, 32'h41);
        bus_read(OFS_STATUS, rd); chk("status_tx2", rd, 32'h0001_0200);
        tx_ready = 1'b1;
        chk("tx_first",  {24'd0, tx_data}, 32'h41);
        cycle();
        chk("tx_second", {24'd0, tx_data}, 32'h42);
        chk("tx_valid_2", {31'd0, tx_valid}, 32'd1);
        cycle();
        chk("tx_drained", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        // Overflow on the 17th write, then clear
        for (int i = 0; i < 17; i++) bus_write(OFS_DATA, 32'h50 + i);
        bus_read(OFS_STATUS, rd); chk("status_tx_full", rd, 32'h0007_1000);
        bus_write(OFS_STATUS, 32'h0004_0000);
        bus_read(OFS_STATUS, rd); chk("status_ovf_clr", rd, 32'h0003_1000);
        tx_ready = 1'b1;
        chk("tx_full_head", {24'd0, tx_data}, 32'h50);
        for (int i = 0; i < 15; i++) cycle();
        chk("tx_full_last", {24'd0, tx_data}, 32'h5F);
        cycle();
        chk("tx_full_drained", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        // Fill RX FIFO, then try one more character which must be refused
        for (int i = 0; i < 16; i++) begin
            rx_valid = 1'b1; rx_data = DB'(i);
            cycle();
        end
        chk("rx_ready_full", {31'd0, rx_ready}, 32'd0);
        rx_data = 8'hEE;
        cycle();
        rx_valid = 1'b0;
        bus_read(OFS_STATUS, rd); chk("status_rx_full", rd, 32'h0008_0010);
        for (int i = 0; i < 16; i++) begin
            bus_read(OFS_DATA, rd);
            chk($sformatf("rx_data_%0d", i), rd, 32'(i));
        end
        bus_read(OFS_DATA, rd); chk("rx_empty_after", rd, 32'h8000_0000);
        chk("rx_ready_empty", {31'd0, rx_ready}, 32'd1);

        // Simultaneous push and pop on a one-entry RX FIFO
        rx_valid = 1'b1; rx_data = 8'h21;
        cycle();
        rx_data = 8'h22;
        bus_read(OFS_DATA, rd);
        rx_valid = 1'b0;
        chk("simul_old_entry", rd, 32'h21);
        bus_read(OFS_STATUS, rd); chk("simul_count", rd, 32'h0000_0001);
        bus_read(OFS_DATA, rd);   chk("simul_new_entry", rd, 32'h22);

`ifdef UART_CTRL_IRQ_EN
        bus_write(OFS_CTRL, 32'h1);
        bus_read(OFS_CTRL, rd); chk("ctrl_read", rd, 32'h1);
        chk("irq_idle", {31'd0, irq}, 32'd0);
        rx_valid = 1'b1; rx_data = 8'h33;
        cycle();
        rx_valid = 1'b0;
        cycle();
        chk("irq_rise", {31'd0, irq}, 32'd1);
        bus_read(OFS_DATA, rd); chk("irq_data", rd, 32'h33);
        chk("irq_hold", {31'd0, irq}, 32'd1);
        cycle();
        chk("irq_fall", {31'd0, irq}, 32'd0);
`else
        bus_write(OFS_CTRL, 32'h3);
        bus_read(OFS_CTRL, rd); chk("ctrl_absent", rd, 32'h0);
`endif

        // Reset mid-transfer: pending ack suppressed, FIFO contents lost
        bus_write(OFS_DATA, 32'h77);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = OFS_STATUS;
        @(posedge clk); #1;
        bus.req = 1'b0;
        rst = 1'b0; #1;
        chk("rst_mid_ack", {31'd0, bus.ack}, 32'd0);
        chk("rst_mid_tx_valid", {31'd0, tx_valid}, 32'd0);
        @(negedge clk); rst = 1'b1;
        cycle();
        bus_read(OFS_STATUS, rd); chk("status_after_rst", rd, 32'h0001_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_ctrl.md
# uart_ctrl

Memory-mapped controller on the CPU side of the UART stream interface: the bus-facing end that feeds the transmitter's data stream and drains the receiver's data stream. Buffers both directions in FIFOs and exposes DATA/STATUS/CTRL registers on a simple single-cycle-request peripheral bus. Sits between the peripheral interconnect and the `uart` block, one instance per UART.

## Interface
- `DATA_BITS`, 8, character width; must match the attached UART.
- `FIFO_DEPTH`, 16, entries per FIFO; power of two, 2..128.
- `clk` input 1: sole clock.
- `rst` input 1: asynchronous reset, active-low.
- `bus_req` input 1: request strobe, one cycle per access.
- `bus_we` input 1: 1 = write, 0 = read.
- `bus_addr` input 4: byte offset; bits [3:2] select the register, [1:0] ignored.
- `bus_wdata` input 32: write data.
- `bus_rdata` output 32: read data, valid while `bus_ack` is high, 0 otherwise.
- `bus_ack` output 1: response, exactly one cycle after each `bus_req`.
- `tx_data` output DATA_BITS: head of TX FIFO, to UART `din`.
- `tx_valid` output 1: TX FIFO non-empty.
- `tx_ready` input 1: UART accepts `tx_data`.
- `rx_data` input DATA_BITS: from UART `dout`.
- `rx_valid` input 1: UART presents a character.
- `rx_ready` output 1: RX FIFO not full.
- `irq` output 1: only with `UART_CTRL_IRQ_EN`.

## Operation
- Registers: 0x0 DATA, 0x4 STATUS, 0x8 CTRL, 0xC reserved (reads 0, writes ignored).
- DATA write: push `bus_wdata[DATA_BITS-1:0]` into TX FIFO; if full, drop and set sticky `tx_overflow`.
- DATA read: pop RX FIFO, return character in low bits, bit 31 = 0; if empty, return 0x8000_0000, no pop.
- STATUS read: [7:0] rx_count, [15:8] tx_count, [16] rx_empty, [17] tx_full, [18] tx_overflow, [19] rx_full; others 0. Write 1 to bit 18 clears `tx_overflow`; other bits read-only.
- Stream side: TX pop on `tx_valid && tx_ready`; RX push on `rx_valid && rx_ready`. Valid/ready per the codebase stream rules: `tx_data` stable while `tx_valid && !tx_ready`.
- Simultaneous push and pop on same FIFO: both occur, count unchanged; on a full FIFO the push is still refused (full/ready decided from registered state).
- Counts width clog2(FIFO_DEPTH)+1, zero-extended into 8-bit fields; no wrap past FIFO_DEPTH.

## Timing
- Reset (rst low, asynchronous): FIFOs empty, pointers 0, `tx_overflow` 0, CTRL 0; outputs `bus_ack`=0, `bus_rdata`=0, `tx_valid`=0, `tx_data`=0, `rx_ready`=1, `irq`=0.
- Access sampled at cycle N with `bus_req`; `bus_ack` and `bus_rdata` at N+1; side effects (push/pop, clear) take effect at edge ending N.
- Back-to-back requests every cycle supported; each gets its own ack.
- Write to empty TX FIFO at N: `tx_valid` high from N+1.
- RX push at cycle M: visible in STATUS/DATA read sampled at M+1 or later.
- Reset asserted mid-transfer: FIFO contents lost, pending ack suppressed.

## Configuration
- `UART_CTRL_IRQ_EN` defined: `irq` port present; CTRL[0] rx_irq_en, CTRL[1] tx_irq_en, readable/writable; `irq` registered, = (rx_irq_en & !rx_empty) | (tx_irq_en & tx_empty), one cycle after the condition.
- Not defined: no `irq` port, CTRL reads 0, writes ignored.

## Structure
- `uart_ctrl_pkg`: register offsets, STATUS bit positions, CTRL bit positions, empty-read flag value.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; push/pop, full/empty/count, show-ahead head), instantiated twice.

## Test plan
- Reset, read STATUS -> 0x0001_0000 (rx_empty only); read DATA -> 0x8000_0000.
- Write 0x41, 0x42 with `tx_ready`=0 -> `tx_valid`=1, `tx_data`=0x41 held, tx_count=2; raise `tx_ready` -> 0x41 then 0x42, then `tx_valid`=0.
- Write 17 characters, `tx_ready`=0, FIFO_DEPTH=16 -> tx_count=16, tx_full=1, tx_overflow=1; write 0x0004_0000 to STATUS -> bit 18 clears.
- Drive 16 RX characters 0x00..0x0F -> `rx_ready`=0, rx_full=1; 16 DATA reads return 0x00..0x0F in order, then 0x8000_0000.
- Simultaneous RX push and DATA read on one-entry RX FIFO -> read returns old entry, rx_count stays 1.
- With `UART_CTRL_IRQ_EN`: CTRL=0x1, push one RX character -> `irq` high next cycle; read DATA -> `irq` low one cycle after pop.
